// File: rtl/shared_mem_arbiter.sv
// ---------------------------------------------------------------------------
// shared_mem_arbiter
//   Serialises shared-memory requests from Ncores cores onto the single
//   SharedMEM port with round-robin arbitration. A request is shared when its
//   address bit [Lmem] is set; private requests are ignored here.
//   One access takes two cycles (ACCESS strobe, RESP ack), and back-to-back
//   grants keep the memory port busy every other cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   coreADDR    per-core address, core i at [i*TAM +: TAM]
//   coreDataIN  per-core write data, same packing
//   coreLoad    per-core load request (level, held until ack)
//   coreWrite   per-core write request (level, held until ack; wins over load)
//   coreStall   core must hold its request and freeze
//   coreAck     one-cycle completion pulse
//   coreRdata   shared read data, valid with coreAck
//   memADDR     shared-memory index (granted address bits [Lmem-1:0])
//   memDataIN   shared-memory write data
//   memLoad     shared read strobe
//   memWrite    shared write strobe
//   memDataOUT  shared-memory read data (valid the cycle after the strobe)
//
// Optional feature macro: SHARED_ARB_STATS_EN
//   Adds statConflict (cycles with >=2 pending shared requests) and statGrants
//   (per-core 16-bit grant counters), all saturating and cleared by reset.
// ---------------------------------------------------------------------------
module shared_mem_arbiter #(
  parameter int Ncores = 2,
  parameter int Lmem   = 8,
  parameter int TAM    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Ncores*TAM-1:0] coreADDR,
  input  logic [Ncores*TAM-1:0] coreDataIN,
  input  logic [Ncores-1:0]     coreLoad,
  input  logic [Ncores-1:0]     coreWrite,
  output logic [Ncores-1:0]     coreStall,
  output logic [Ncores-1:0]     coreAck,
  output logic [TAM-1:0]        coreRdata,
  output logic [Lmem-1:0]       memADDR,
  output logic [TAM-1:0]        memDataIN,
  output logic                  memLoad,
  output logic                  memWrite,
  input  logic [TAM-1:0]        memDataOUT
`ifdef SHARED_ARB_STATS_EN
  ,
  output logic [15:0]           statConflict,
  output logic [Ncores*16-1:0]  statGrants
`endif
);

  localparam int PW = (Ncores > 1) ? $clog2(Ncores) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g_q, g_d;

  logic [TAM-1:0]  addr_a [Ncores];
  logic [TAM-1:0]  data_a [Ncores];
  logic [Ncores-1:0] pend;

  for (genvar i = 0; i < Ncores; i++) begin : g_unpack
    assign addr_a[i] = coreADDR[i*TAM +: TAM];
    assign data_a[i] = coreDataIN[i*TAM +: TAM];
    assign pend[i]   = (coreLoad[i] | coreWrite[i]) & addr_a[i][Lmem];
  end

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (v == PW'(Ncores - 1)) return '0;
    return v + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
    end
  end

  // Next-state: round-robin search from ptr; in RESP the current grantee is
  // masked so a core cannot win twice in a row while others wait.
  logic [Ncores-1:0] req;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     win;
  logic              found;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    req     = pend;
    if (state_q == RESP) req[g_q] = 1'b0;
    idx   = ptr_q;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < Ncores; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = wrap_inc(idx);
    end
    case (state_q)
      IDLE, RESP: begin
        if (found) begin
          state_d = ACCESS;
          g_d     = win;
          ptr_d   = wrap_inc(win);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: strobes follow the granted core's live inputs during ACCESS.
  always_comb begin
    coreAck   = '0;
    coreRdata = '0;
    memADDR   = '0;
    memDataIN = '0;
    memLoad   = 1'b0;
    memWrite  = 1'b0;
    case (state_q)
      ACCESS: begin
        memADDR   = addr_a[g_q][Lmem-1:0];
        memDataIN = data_a[g_q];
        memWrite  = coreWrite[g_q];
        memLoad   = coreLoad[g_q] & ~coreWrite[g_q];
      end
      RESP: begin
        coreAck[g_q] = 1'b1;
        coreRdata    = memDataOUT;
      end
      default: ;
    endcase
    coreStall = pend & ~coreAck;
  end

`ifdef SHARED_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;
  logic [15:0] grants_q [Ncores];
  logic [15:0] grants_d [Ncores];
  logic [3:0]  pend_cnt;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < Ncores; i++) pend_cnt = pend_cnt + {3'b000, pend[i]};
    conflict_d = conflict_q;
    if (pend_cnt >= 4'd2 && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
    for (int i = 0; i < Ncores; i++) begin
      grants_d[i] = grants_q[i];
      if (state_q != ACCESS && state_d == ACCESS && g_d == PW'(i) &&
          grants_q[i] != 16'hFFFF)
        grants_d[i] = grants_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
      for (int i = 0; i < Ncores; i++) grants_q[i] <= '0;
    end else begin
      conflict_q <= conflict_d;
      for (int i = 0; i < Ncores; i++) grants_q[i] <= grants_d[i];
    end
  end

  assign statConflict = conflict_q;
  for (genvar i = 0; i < Ncores; i++) begin : g_stat
    assign statGrants[i*16 +: 16] = grants_q[i];
  end
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_mem_arbiter
//   Directed bench for shared_mem_arbiter (Ncores=2, Lmem=8, TAM=16).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   after a further settle delay, well away from the edge.
// ---------------------------------------------------------------------------
module tb_shared_mem_arbiter;

  localparam int N = 2;
  localparam int L = 8;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*T-1:0] coreADDR;
  logic [N*T-1:0] coreDataIN;
  logic [N-1:0]   coreLoad;
  logic [N-1:0]   coreWrite;
  logic [N-1:0]   coreStall;
  logic [N-1:0]   coreAck;
  logic [T-1:0]   coreRdata;
  logic [L-1:0]   memADDR;
  logic [T-1:0]   memDataIN;
  logic           memLoad;
  logic           memWrite;
  logic [T-1:0]   memDataOUT;
`ifdef SHARED_ARB_STATS_EN
  logic [15:0]    statConflict;
  logic [N*16-1:0] statGrants;
`endif

  int tests    = 0;
  int failures = 0;

  shared_mem_arbiter #(.Ncores(N), .Lmem(L), .TAM(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .coreADDR   (coreADDR),
    .coreDataIN (coreDataIN),
    .coreLoad   (coreLoad),
    .coreWrite  (coreWrite),
    .coreStall  (coreStall),
    .coreAck    (coreAck),
    .coreRdata  (coreRdata),
    .memADDR    (memADDR),
    .memDataIN  (memDataIN),
    .memLoad    (memLoad),
    .memWrite   (memWrite),
    .memDataOUT (memDataOUT)
`ifdef SHARED_ARB_STATS_EN
    ,
    .statConflict (statConflict),
    .statGrants   (statGrants)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    coreADDR   = '0;
    coreDataIN = '0;
    coreLoad   = '0;
    coreWrite  = '0;
    memDataOUT = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst        = 1'b0;
    coreADDR   = {16'h0000, 16'h0111};
    coreDataIN = '0;
    coreLoad   = '0;
    coreWrite  = 2'b01;
    memDataOUT = 16'h1234;
    tick();
    tick();
    check("rst_memWrite",  32'(memWrite),  32'h0);
    check("rst_memLoad",   32'(memLoad),   32'h0);
    check("rst_memADDR",   32'(memADDR),   32'h0);
    check("rst_memDataIN", 32'(memDataIN), 32'h0);
    check("rst_coreAck",   32'(coreAck),   32'h0);
    check("rst_coreRdata", 32'(coreRdata), 32'h0);
    check("rst_stall_follows_pend", 32'(coreStall), 32'h1);
`ifdef SHARED_ARB_STATS_EN
    check("rst_statConflict", 32'(statConflict), 32'h0);
`endif
    do_reset();

    // ---------------- single core 0 shared load ----------------
    coreADDR = {16'h0000, 16'h0105};
    coreLoad = 2'b01;
    settle();
    check("t1_N_stall",   32'(coreStall), 32'h1);
    check("t1_N_memLoad", 32'(memLoad),   32'h0);
    tick();
    check("t1_N1_memLoad",  32'(memLoad),  32'h1);
    check("t1_N1_memWrite", 32'(memWrite), 32'h0);
    check("t1_N1_memADDR",  32'(memADDR),  32'h05);
    check("t1_N1_stall",    32'(coreStall), 32'h1);
    check("t1_N1_ack",      32'(coreAck),  32'h0);
    memDataOUT = 16'hBEEF;
    tick();
    check("t1_N2_ack",     32'(coreAck),   32'h1);
    check("t1_N2_rdata",   32'(coreRdata), 32'hBEEF);
    check("t1_N2_stall",   32'(coreStall), 32'h0);
    check("t1_N2_memLoad", 32'(memLoad),   32'h0);
    coreLoad = 2'b00;
    tick();
    check("t1_N3_ack",   32'(coreAck),   32'h0);
    check("t1_N3_rdata", 32'(coreRdata), 32'h0);
    check("t1_N3_stall", 32'(coreStall), 32'h0);

    // ---------------- both cores write from reset ----------------
    do_reset();
    coreADDR   = {16'h0122, 16'h0133};
    coreDataIN = {16'hB222, 16'hA111};
    coreWrite  = 2'b11;
    settle();
    check("t2_N_stall", 32'(coreStall), 32'h3);
    tick();
    check("t2_N1_memWrite",  32'(memWrite),  32'h1);
    check("t2_N1_memDataIN", 32'(memDataIN), 32'hA111);
    check("t2_N1_memADDR",   32'(memADDR),   32'h33);
    check("t2_N1_ack",       32'(coreAck),   32'h0);
    tick();
    check("t2_N2_ack",      32'(coreAck),  32'h1);
    check("t2_N2_memWrite", 32'(memWrite), 32'h0);
    coreWrite = 2'b10;
    settle();
    check("t2_N2_stall", 32'(coreStall), 32'h2);
    tick();
    check("t2_N3_memWrite",  32'(memWrite),  32'h1);
    check("t2_N3_memDataIN", 32'(memDataIN), 32'hB222);
    check("t2_N3_memADDR",   32'(memADDR),   32'h22);
    tick();
    check("t2_N4_ack", 32'(coreAck), 32'h2);
    coreWrite = 2'b00;
    tick();
    check("t2_N5_ack",      32'(coreAck),  32'h0);
    check("t2_N5_memWrite", 32'(memWrite), 32'h0);

    // ---------------- continuous contention, 8 accesses ----------------
    do_reset();
    coreADDR = {16'h0144, 16'h0155};
    coreLoad = 2'b11;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("t3_memLoad", 32'(memLoad), 32'h1);
      check("t3_memADDR", 32'(memADDR), (k % 2 == 0) ? 32'h55 : 32'h44);
      tick();
      check("t3_ack", 32'(coreAck), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 7) coreLoad = 2'b00;
      tick();
    end
    check("t3_end_ack",     32'(coreAck), 32'h0);
    check("t3_end_memLoad", 32'(memLoad), 32'h0);

    // ---------------- private write on core 1, shared load on core 0 ----------------
    do_reset();
    coreADDR  = {16'h0005, 16'h0177};
    coreLoad  = 2'b01;
    coreWrite = 2'b10;
    settle();
    check("t4_N_stall", 32'(coreStall), 32'h1);
    tick();
    check("t4_N1_memLoad",  32'(memLoad),  32'h1);
    check("t4_N1_memWrite", 32'(memWrite), 32'h0);
    check("t4_N1_stall",    32'(coreStall), 32'h1);
    check("t4_N1_ack",      32'(coreAck),  32'h0);
    tick();
    check("t4_N2_ack", 32'(coreAck), 32'h1);
    coreLoad = 2'b00;
    tick();
    check("t4_N3_ack",      32'(coreAck),   32'h0);
    check("t4_N3_stall",    32'(coreStall), 32'h0);
    check("t4_N3_memWrite", 32'(memWrite),  32'h0);
    coreWrite = 2'b00;

    // ---------------- reset asserted during ACCESS ----------------
    do_reset();
    coreADDR   = {16'h0000, 16'h0188};
    coreDataIN = {16'h0000, 16'h5A5A};
    coreWrite  = 2'b01;
    tick();
    check("t5_access_memWrite", 32'(memWrite), 32'h1);
    rst = 1'b0;
    settle();
    check("t5_rst_memWrite",  32'(memWrite),  32'h0);
    check("t5_rst_memADDR",   32'(memADDR),   32'h0);
    check("t5_rst_memDataIN", 32'(memDataIN), 32'h0);
    check("t5_rst_ack",       32'(coreAck),   32'h0);
    check("t5_rst_stall",     32'(coreStall), 32'h1);
    tick();
    rst = 1'b1;
    settle();
    check("t5_M_memWrite", 32'(memWrite), 32'h0);
    tick();
    check("t5_M1_memWrite",  32'(memWrite),  32'h1);
    check("t5_M1_memADDR",   32'(memADDR),   32'h88);
    check("t5_M1_memDataIN", 32'(memDataIN), 32'h5A5A);
    tick();
    check("t5_M2_ack", 32'(coreAck), 32'h1);
    coreWrite = 2'b00;
    tick();
    check("t5_M3_ack", 32'(coreAck), 32'h0);

`ifdef SHARED_ARB_STATS_EN
    // ---------------- statistics: 5 cycles of dual contention ----------------
    do_reset();
    settle();
    check("t6_conflict_clear", 32'(statConflict), 32'h0);
    coreADDR = {16'h01A2, 16'h01A1};
    coreLoad = 2'b11;
    tick();
    check("t6_c1_ack", 32'(coreAck), 32'h0);
    tick();
    check("t6_c2_ack", 32'(coreAck), 32'h1);
    tick();
    check("t6_c3_ack", 32'(coreAck), 32'h0);
    tick();
    check("t6_c4_ack", 32'(coreAck), 32'h2);
    tick();
    coreLoad = 2'b00;
    tick();
    check("t6_c6_ack", 32'(coreAck), 32'h1);
    tick();
    check("t6_c7_ack",      32'(coreAck),          32'h0);
    check("t6_statConflict", 32'(statConflict),    32'd5);
    check("t6_grants_core0", 32'(statGrants[15:0]),  32'd2);
    check("t6_grants_core1", 32'(statGrants[31:16]), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
